mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Parametrised successor to the pipeline's memory stage. Accepts one instruction per handshake from EX and performs byte/half/word loads and stores and NoC loads/stores against a variable-latency RAM port using a valid/ready request and a valid response. Forwards non-memory results to WB. Adds alignment checking, byte enables, sign/zero extension, stall back-pressure and a response timeout.

Parameters:
XLEN, 32, data/address width (multiple of 8, at least 32)
REG_AW, 5, register-file address width
TIMEOUT_CYCLES, 255, maximum cycles in WAIT_RSP before abort (≥1)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  EX presents an instruction
in_ready  out  1  unit accepts the instruction (in_valid & in_ready = accept)
in_op  in  4  memory op code (mem_op_t from package)
in_addr  in  XLEN  effective address from EX
in_wdata  in  XLEN  store / NoC-load data
in_rd_addr  in  REG_AW  destination register
in_rd_we  in  1  destination write enable
in_rd_data  in  XLEN  ALU result for non-memory ops
in_inst  in  32  instruction word (trace)
ram_req_valid  out  1  request valid
ram_req_ready  in  1  RAM accepts request
ram_req_addr  out  XLEN  word-aligned address (low 2 bits zero)
ram_req_we  out  1  1 = write
ram_req_be  out  XLEN/8  byte enables
ram_req_wdata  out  XLEN  lane-aligned write data
ram_rsp_valid  in  1  read data valid
ram_rsp_data  in  XLEN  read word
wb_valid  out  1  one-cycle pulse, WB fields valid
wb_rd_addr  out  REG_AW  to WB
wb_rd_we  out  1  to WB
wb_rd_data  out  XLEN  to WB
wb_inst  out  32  trace
stall  out  1  equals ~in_ready
err_misaligned  out  1  one-cycle pulse with wb_valid
err_timeout  out  1  one-cycle pulse with wb_valid

Behaviour:
- Reset (reset_n=0, any time, including mid-transaction): state IDLE; every output zero except in_ready=1 and stall=0; timeout counter zero; any in-flight request is dropped and a late ram_rsp_valid is ignored.
- FSM states: IDLE, REQ, WAIT_RSP. in_ready = (state==IDLE). All outputs are registered.
- IDLE, accept, MEM_NONE: the next cycle drives wb_valid=1 with in_rd_* passed through. Latency 1.
- IDLE, accept, aligned memory op: latch op/addr/data/rd/inst, then go to REQ.
- IDLE, accept, misaligned op (LH/LHU/SH with addr[0]≠0; LW/SW/LOADNOC/STORENOC with addr[1:0]≠0): no RAM request. Next cycle: wb_valid=1, wb_rd_we=0, err_misaligned=1. Stay in IDLE.
- REQ: hold ram_req_* stable until ram_req_ready. On the handshake, a write goes to IDLE and pulses wb_valid with wb_rd_we=0 the next cycle; a read goes to WAIT_RSP. If ram_rsp_valid arrives in the same cycle as the read handshake, it is ignored.
- Write encodings:
  - SB: be = 1<<addr[1:0], byte replicated on all lanes.
  - SH: be = 0b11<<addr[1:0], halfword replicated.
  - SW: be = all ones.
  - LOADNOC: write of in_wdata, be = all ones.
  - STORENOC: write of zero, be = all ones.
- Read encodings: be = all ones, we=0.
- WAIT_RSP: counter increments each cycle. On ram_rsp_valid, extract the lane at addr[1:0]*8. LB/LH sign-extend, LBU/LHU zero-extend, LW takes the full word. Next cycle: wb_valid=1, wb_rd_we=latched rd_we, then go to IDLE. If the counter reaches TIMEOUT_CYCLES without a response: wb_valid=1, wb_rd_we=0, err_timeout=1, go to IDLE. If ram_rsp_valid arrives in the same cycle the counter hits the limit, the response wins.
- Loads with rd_addr==0: wb_rd_we forced to 0.
- Only one transaction is outstanding; no new accept before the unit returns to IDLE.

Decomposition:
- Package mem_access_pkg: mem_op_t encodings (MEM_NONE, LB, LH, LW, LBU, LHU, SB, SH, SW, LOADNOC, STORENOC), FSM state type, and an is_load / is_store helper function.
- One sub-module, mem_lane_align: combinational store byte-enable/data replication and load extract/extension. It is shared by the FSM and reusable by the bench as a reference model.

Test Plan:
- MEM_NONE, rd=5, rd_data=0x1234 → wb_valid one cycle later with rd=5, data 0x1234, no ram_req_valid.
- SB addr=0x103, wdata=0xAB with ram_req_ready held low 3 cycles → ram_req_addr=0x100, be=0b1000, wdata=0xABABABAB, stable for 4 cycles; then wb_valid with wb_rd_we=0.
- LB addr=0x102, response 0x00F00000 after 5 cycles → wb_rd_data=0xFFFFFFF0. Same stimulus with LBU → 0x000000F0.
- LW addr=0x202 → err_misaligned and wb_valid next cycle, wb_rd_we=0, ram_req_valid never asserted.
- LW with no response and TIMEOUT_CYCLES=8 → err_timeout after 8 cycles in WAIT_RSP, wb_rd_we=0, in_ready=1 the following cycle.
- reset_n pulled low in WAIT_RSP, then a late ram_rsp_valid → all outputs 0, in_ready=1, no wb_valid generated.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types for the memory access unit: op codes, FSM state and op classification helpers.
package mem_access_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    LB       = 4'd1,
    LH       = 4'd2,
    LW       = 4'd3,
    LBU      = 4'd4,
    LHU      = 4'd5,
    SB       = 4'd6,
    SH       = 4'd7,
    SW       = 4'd8,
    LOADNOC  = 4'd9,
    STORENOC = 4'd10
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  function automatic logic is_load(input mem_op_t op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

  // LOADNOC pushes data out to the NoC, so from the RAM's point of view it is a write.
  function automatic logic is_store(input mem_op_t op);
    return (op == SB) || (op == SH) || (op == SW) || (op == LOADNOC) || (op == STORENOC);
  endfunction

  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] off);
    case (op)
      LH, LHU, SH:               return off[0];
      LW, SW, LOADNOC, STORENOC: return off != 2'b00;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// EX, RAM and WB facing signals of the memory access unit.
interface mem_access_if
  import mem_access_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // The sender holds valid and payload stable until that edge; ram_rsp_valid has no ready.
  logic                in_valid;
  logic                in_ready;
  mem_op_t             in_op;
  logic [XLEN-1:0]     in_addr;
  logic [XLEN-1:0]     in_wdata;
  logic [REG_AW-1:0]   in_rd_addr;
  logic                in_rd_we;
  logic [XLEN-1:0]     in_rd_data;
  logic [31:0]         in_inst;
  logic                ram_req_valid;
  logic                ram_req_ready;
  logic [XLEN-1:0]     ram_req_addr;
  logic                ram_req_we;
  logic [XLEN/8-1:0]   ram_req_be;
  logic [XLEN-1:0]     ram_req_wdata;
  logic                ram_rsp_valid;
  logic [XLEN-1:0]     ram_rsp_data;
  logic                wb_valid;
  logic [REG_AW-1:0]   wb_rd_addr;
  logic                wb_rd_we;
  logic [XLEN-1:0]     wb_rd_data;
  logic [31:0]         wb_inst;
  logic                stall;
  logic                err_misaligned;
  logic                err_timeout;

  modport slave (
    input  in_valid, in_op, in_addr, in_wdata, in_rd_addr, in_rd_we, in_rd_data, in_inst,
    input  ram_req_ready, ram_rsp_valid, ram_rsp_data,
    output in_ready, ram_req_valid, ram_req_addr, ram_req_we, ram_req_be, ram_req_wdata,
    output wb_valid, wb_rd_addr, wb_rd_we, wb_rd_data, wb_inst, stall, err_misaligned,
    output err_timeout
  );

  modport master (
    output in_valid, in_op, in_addr, in_wdata, in_rd_addr, in_rd_we, in_rd_data, in_inst,
    output ram_req_ready, ram_rsp_valid, ram_rsp_data,
    input  in_ready, ram_req_valid, ram_req_addr, ram_req_we, ram_req_be, ram_req_wdata,
    input  wb_valid, wb_rd_addr, wb_rd_we, wb_rd_data, wb_inst, stall, err_misaligned,
    input  err_timeout
  );
endinterface

// File: rtl/mem_access_unit_lane.sv
// Combinational lane steering: store byte enables / replicated data, load lane extract and extension.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mem_op_t           op,
  input  logic [1:0]        offset,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata_lane,
  output logic [XLEN-1:0]   rdata_ext
);
  localparam int BW = XLEN / 8;

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted    = rdata >> {offset, 3'b000};
    be         = '1;
    wdata_lane = '0;
    rdata_ext  = rdata;
    case (op)
      SB: begin
        be         = BW'(1) << offset;
        wdata_lane = {(XLEN/8){wdata[7:0]}};
      end
      SH: begin
        be         = BW'(3) << offset;
        wdata_lane = {(XLEN/16){wdata[15:0]}};
      end
      SW, LOADNOC: wdata_lane = wdata;
      LB:          rdata_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LBU:         rdata_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LH:          rdata_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LHU:         rdata_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Pipeline memory stage: one instruction at a time, loads/stores against a variable-latency RAM.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_AW         = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_access_if.slave  bus,
  output state_t       dbg_state
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state_q, state_d;
  mem_op_t           op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic              rd_we_q, rd_we_d;
  logic [31:0]       inst_q, inst_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              req_valid_q, req_valid_d, req_we_q, req_we_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
  logic [XLEN/8-1:0] req_be_q, req_be_d;
  logic              wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [31:0]       wb_inst_q, wb_inst_d;
  logic              mis_q, mis_d, to_q, to_d;

  mem_op_t           al_op;
  logic [1:0]        al_off;
  logic [XLEN/8-1:0] al_be;
  logic [XLEN-1:0]   al_wdata, al_rdata;

  // IDLE only ever encodes a new store and WAIT_RSP only extracts a load, so one aligner serves both.
  assign al_op  = (state_q == IDLE) ? bus.in_op : op_q;
  assign al_off = (state_q == IDLE) ? bus.in_addr[1:0] : off_q;

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .op(al_op), .offset(al_off), .wdata(bus.in_wdata), .rdata(bus.ram_rsp_data),
    .be(al_be), .wdata_lane(al_wdata), .rdata_ext(al_rdata)
  );

  always_comb begin
    state_d = state_q;  op_d = op_q;  off_d = off_q;
    rd_addr_d = rd_addr_q;  rd_we_d = rd_we_q;  inst_d = inst_q;  cnt_d = cnt_q;
    req_valid_d = req_valid_q;  req_we_d = req_we_q;  req_addr_d = req_addr_q;
    req_wdata_d = req_wdata_q;  req_be_d = req_be_q;
    wb_valid_d = 1'b0;  wb_we_d = wb_we_q;  wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;  wb_inst_d = wb_inst_q;  mis_d = 1'b0;  to_d = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        wb_addr_d = bus.in_rd_addr;
        wb_inst_d = bus.in_inst;
        if (!is_load(bus.in_op) && !is_store(bus.in_op)) begin
          wb_valid_d = 1'b1;
          wb_we_d    = bus.in_rd_we;
          wb_data_d  = bus.in_rd_data;
        end else if (is_misaligned(bus.in_op, bus.in_addr[1:0])) begin
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b0;
          wb_data_d  = '0;
          mis_d      = 1'b1;
        end else begin
          op_d        = bus.in_op;
          off_d       = bus.in_addr[1:0];
          rd_addr_d   = bus.in_rd_addr;
          rd_we_d     = bus.in_rd_we;
          inst_d      = bus.in_inst;
          req_valid_d = 1'b1;
          req_addr_d  = {bus.in_addr[XLEN-1:2], 2'b00};
          req_we_d    = is_store(bus.in_op);
          req_be_d    = al_be;
          req_wdata_d = al_wdata;
          state_d     = REQ;
        end
      end
      REQ: if (bus.ram_req_ready) begin
        req_valid_d = 1'b0;
        cnt_d       = '0;
        if (is_store(op_q)) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b0;
          wb_addr_d  = rd_addr_q;
          wb_data_d  = '0;
          wb_inst_d  = inst_q;
        end else begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        wb_addr_d = rd_addr_q;
        wb_inst_d = inst_q;
        if (bus.ram_rsp_valid) begin
          state_d    = IDLE;
          cnt_d      = '0;
          wb_valid_d = 1'b1;
          wb_we_d    = rd_we_q && (rd_addr_q != '0);
          wb_data_d  = al_rdata;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d    = IDLE;
          cnt_d      = '0;
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b0;
          wb_data_d  = '0;
          to_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;  op_q <= MEM_NONE;  off_q <= '0;
      rd_addr_q <= '0;  rd_we_q <= 1'b0;  inst_q <= '0;  cnt_q <= '0;
      req_valid_q <= 1'b0;  req_we_q <= 1'b0;  req_addr_q <= '0;
      req_wdata_q <= '0;  req_be_q <= '0;
      wb_valid_q <= 1'b0;  wb_we_q <= 1'b0;  wb_addr_q <= '0;
      wb_data_q <= '0;  wb_inst_q <= '0;  mis_q <= 1'b0;  to_q <= 1'b0;
    end else begin
      state_q <= state_d;  op_q <= op_d;  off_q <= off_d;
      rd_addr_q <= rd_addr_d;  rd_we_q <= rd_we_d;  inst_q <= inst_d;  cnt_q <= cnt_d;
      req_valid_q <= req_valid_d;  req_we_q <= req_we_d;  req_addr_q <= req_addr_d;
      req_wdata_q <= req_wdata_d;  req_be_q <= req_be_d;
      wb_valid_q <= wb_valid_d;  wb_we_q <= wb_we_d;  wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;  wb_inst_q <= wb_inst_d;  mis_q <= mis_d;  to_q <= to_d;
    end
  end

  assign bus.in_ready       = (state_q == IDLE);
  assign bus.stall          = (state_q != IDLE);
  assign bus.ram_req_valid  = req_valid_q;
  assign bus.ram_req_addr   = req_addr_q;
  assign bus.ram_req_we     = req_we_q;
  assign bus.ram_req_be     = req_be_q;
  assign bus.ram_req_wdata  = req_wdata_q;
  assign bus.wb_valid       = wb_valid_q;
  assign bus.wb_rd_addr     = wb_addr_q;
  assign bus.wb_rd_we       = wb_we_q;
  assign bus.wb_rd_data     = wb_data_q;
  assign bus.wb_inst        = wb_inst_q;
  assign bus.err_misaligned = mis_q;
  assign bus.err_timeout    = to_q;
  assign dbg_state          = state_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of hand-computed vectors plus reset corner sequences.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int TO = 8;

  logic   clk = 1'b0;
  logic   reset_n = 1'b0;
  state_t dbg_state;
  int     total = 0;
  int     bad = 0;

  mem_access_if #(.XLEN(32), .REG_AW(5)) bus ();

  mem_access_unit #(.XLEN(32), .REG_AW(5), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    mem_op_t     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] rd_data;
    int          ready_dly;
    int          rsp_dly;     // 0 = RAM never answers
    logic [31:0] rsp_data;
    bit          junk;        // spurious response on the request handshake edge
    bit          exp_req;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_wb_we;
    bit          chk_data;
    logic [31:0] exp_data;
    bit          exp_mis;
    bit          exp_to;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.in_valid = 1'b0;  bus.in_op = MEM_NONE;  bus.in_addr = '0;  bus.in_wdata = '0;
    bus.in_rd_addr = '0;  bus.in_rd_we = 1'b0;  bus.in_rd_data = '0;  bus.in_inst = '0;
    bus.ram_req_ready = 1'b0;  bus.ram_rsp_valid = 1'b0;  bus.ram_rsp_data = '0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
    chk({tag, "_req_valid"}, 32'(bus.ram_req_valid), 32'd0);
    chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
    chk({tag, "_errs"}, {30'd0, bus.err_misaligned, bus.err_timeout}, 32'd0);
    chk({tag, "_wb_data"}, bus.wb_rd_data, 32'd0);
    chk({tag, "_req_fields"}, {bus.ram_req_addr[27:0], bus.ram_req_be}, 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          req_seen = 0;
    int          since_hs = 0;
    int          extra_req = 0;
    int          cyc;
    bit          hs = 0;
    bit          wb_seen = 0;
    bit          stable = 1;
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    logic        we0;
    logic [31:0] inst = 32'h0000_1000 + 32'(idx);
    string       t = $sformatf("v%0d", idx);

    @(negedge clk);
    chk({t, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;  bus.in_op = v.op;  bus.in_addr = v.addr;  bus.in_wdata = v.wdata;
    bus.in_rd_addr = v.rd;  bus.in_rd_we = v.rd_we;  bus.in_rd_data = v.rd_data;
    bus.in_inst = inst;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_op = MEM_NONE;
    for (cyc = 1; cyc <= 60; cyc++) begin
      bus.ram_req_ready = 1'b0;
      bus.ram_rsp_valid = 1'b0;
      if (bus.wb_valid) begin
        wb_seen = 1;
        break;
      end
      if (hs) begin
        since_hs++;
        if (bus.ram_req_valid) extra_req++;
        if (v.rsp_dly != 0 && since_hs == v.rsp_dly) begin
          bus.ram_rsp_valid = 1'b1;
          bus.ram_rsp_data  = v.rsp_data;
        end
      end else if (bus.ram_req_valid) begin
        if (req_seen == 0) begin
          a0 = bus.ram_req_addr;  w0 = bus.ram_req_wdata;  b0 = bus.ram_req_be;
          we0 = bus.ram_req_we;
          chk({t, "_req_addr"}, a0, v.exp_addr);
          chk({t, "_req_we"}, 32'(we0), 32'(v.exp_we));
          chk({t, "_req_be"}, 32'(b0), 32'(v.exp_be));
          if (v.exp_we) chk({t, "_req_wdata"}, w0, v.exp_wdata);
          chk({t, "_busy_ready"}, {30'd0, bus.in_ready, bus.stall}, 32'd1);
        end else if (bus.ram_req_addr !== a0 || bus.ram_req_wdata !== w0 ||
                     bus.ram_req_be !== b0 || bus.ram_req_we !== we0) begin
          stable = 0;
        end
        req_seen++;
        if (req_seen == v.ready_dly + 1) begin
          bus.ram_req_ready = 1'b1;
          hs = 1;
          if (v.junk) begin
            bus.ram_rsp_valid = 1'b1;
            bus.ram_rsp_data  = 32'hFFFF_FFFF;
          end
        end
      end
      @(negedge clk);
    end
    chk({t, "_wb_seen"}, 32'(wb_seen), 32'd1);
    chk({t, "_req_issued"}, 32'(req_seen != 0), 32'(v.exp_req));
    if (v.exp_req) begin
      chk({t, "_req_hold"}, 32'(req_seen), 32'(v.ready_dly + 1));
      chk({t, "_req_stable"}, 32'(stable), 32'd1);
      chk({t, "_req_drop"}, 32'(extra_req), 32'd0);
    end else begin
      chk({t, "_latency"}, 32'(cyc), 32'd1);
    end
    chk({t, "_wb_we"}, 32'(bus.wb_rd_we), 32'(v.exp_wb_we));
    chk({t, "_err_mis"}, 32'(bus.err_misaligned), 32'(v.exp_mis));
    chk({t, "_err_to"}, 32'(bus.err_timeout), 32'(v.exp_to));
    if (v.exp_to) chk({t, "_to_wait"}, 32'(since_hs), 32'(TO));
    if (v.chk_data) begin
      chk({t, "_wb_data"}, bus.wb_rd_data, v.exp_data);
      chk({t, "_wb_rd"}, 32'(bus.wb_rd_addr), 32'(v.rd));
      chk({t, "_wb_inst"}, bus.wb_inst, inst);
    end
    @(negedge clk);
    chk({t, "_wb_pulse"}, {29'd0, bus.wb_valid, bus.err_misaligned, bus.err_timeout}, 32'd0);
    chk({t, "_back_idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int   guard;
    logic saw_wb;

    //          op        addr          wdata          rd  we rd_data      rdy rsp rsp_data      jk req exp_addr      we be      exp_wdata      wbwe cd exp_data      mis to
    vecs[0]  = '{MEM_NONE, 32'h0,        32'h0,         5,  1, 32'h1234,    0,  0,  32'h0,        0, 0,  32'h0,        0, 4'h0,   32'h0,         1,   1, 32'h1234,     0,  0};
    vecs[1]  = '{SB,       32'h103,      32'hAB,        6,  0, 32'h0,       3,  0,  32'h0,        0, 1,  32'h100,      1, 4'b1000, 32'hABABABAB, 0,   0, 32'h0,        0,  0};
    vecs[2]  = '{LB,       32'h102,      32'h0,         7,  1, 32'h0,       0,  5,  32'h00F00000, 0, 1,  32'h100,      0, 4'hF,   32'h0,         1,   1, 32'hFFFFFFF0, 0,  0};
    vecs[3]  = '{LBU,      32'h102,      32'h0,         7,  1, 32'h0,       0,  5,  32'h00F00000, 0, 1,  32'h100,      0, 4'hF,   32'h0,         1,   1, 32'h000000F0, 0,  0};
    vecs[4]  = '{LW,       32'h202,      32'h0,         8,  1, 32'h0,       0,  0,  32'h0,        0, 0,  32'h0,        0, 4'h0,   32'h0,         0,   0, 32'h0,        1,  0};
    vecs[5]  = '{LW,       32'h100,      32'h0,         9,  1, 32'h0,       1,  0,  32'h0,        0, 1,  32'h100,      0, 4'hF,   32'h0,         0,   0, 32'h0,        0,  1};
    vecs[6]  = '{SH,       32'h102,      32'h1234BEEF,  1,  0, 32'h0,       0,  0,  32'h0,        0, 1,  32'h100,      1, 4'b1100, 32'hBEEFBEEF, 0,   0, 32'h0,        0,  0};
    vecs[7]  = '{SW,       32'h204,      32'hCAFEF00D,  2,  0, 32'h0,       2,  0,  32'h0,        0, 1,  32'h204,      1, 4'hF,   32'hCAFEF00D,  0,   0, 32'h0,        0,  0};
    vecs[8]  = '{LOADNOC,  32'h300,      32'h55AA55AA,  3,  0, 32'h0,       1,  0,  32'h0,        0, 1,  32'h300,      1, 4'hF,   32'h55AA55AA,  0,   0, 32'h0,        0,  0};
    vecs[9]  = '{STORENOC, 32'h304,      32'hFFFFFFFF,  4,  0, 32'h0,       0,  0,  32'h0,        0, 1,  32'h304,      1, 4'hF,   32'h0,         0,   0, 32'h0,        0,  0};
    vecs[10] = '{LH,       32'h102,      32'h0,         10, 1, 32'h0,       0,  2,  32'h80010000, 0, 1,  32'h100,      0, 4'hF,   32'h0,         1,   1, 32'hFFFF8001, 0,  0};
    vecs[11] = '{LHU,      32'h102,      32'h0,         10, 1, 32'h0,       0,  2,  32'h80010000, 0, 1,  32'h100,      0, 4'hF,   32'h0,         1,   1, 32'h00008001, 0,  0};
    vecs[12] = '{LW,       32'h100,      32'h0,         11, 1, 32'h0,       0,  8,  32'hDEADBEEF, 0, 1,  32'h100,      0, 4'hF,   32'h0,         1,   1, 32'hDEADBEEF, 0,  0};
    vecs[13] = '{LW,       32'h108,      32'h0,         0,  1, 32'h0,       0,  1,  32'h00000011, 0, 1,  32'h108,      0, 4'hF,   32'h0,         0,   0, 32'h0,        0,  0};
    vecs[14] = '{LB,       32'h101,      32'h0,         12, 1, 32'h0,       0,  3,  32'h00007F00, 1, 1,  32'h100,      0, 4'hF,   32'h0,         1,   1, 32'h0000007F, 0,  0};
    vecs[15] = '{SH,       32'h101,      32'h1234,      13, 0, 32'h0,       0,  0,  32'h0,        0, 0,  32'h0,        0, 4'h0,   32'h0,         0,   0, 32'h0,        1,  0};
    vecs[16] = '{LHU,      32'h103,      32'h0,         14, 1, 32'h0,       0,  0,  32'h0,        0, 0,  32'h0,        0, 4'h0,   32'h0,         0,   0, 32'h0,        1,  0};
    vecs[17] = '{SB,       32'h100,      32'h12345678,  15, 0, 32'h0,       0,  0,  32'h0,        0, 1,  32'h100,      1, 4'b0001, 32'h78787878, 0,   0, 32'h0,        0,  0};
    vecs[18] = '{LW,       32'h10C,      32'h0,         16, 1, 32'h0,       0,  9,  32'h12345678, 0, 1,  32'h10C,      0, 4'hF,   32'h0,         0,   0, 32'h0,        0,  1};
    vecs[19] = '{STORENOC, 32'h302,      32'h0,         17, 0, 32'h0,       0,  0,  32'h0,        0, 0,  32'h0,        0, 4'h0,   32'h0,         0,   0, 32'h0,        1,  0};
    vecs[20] = '{LB,       32'h103,      32'h0,         18, 1, 32'h0,       1,  1,  32'h80000000, 0, 1,  32'h100,      0, 4'hF,   32'h0,         1,   1, 32'hFFFFFF80, 0,  0};

    clear_inputs();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("por");
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) run_vec(i, vecs[i]);

    // Reset while waiting for a load response, then a late response must not reach WB.
    @(negedge clk);
    bus.in_valid = 1'b1;  bus.in_op = LW;  bus.in_addr = 32'h400;  bus.in_rd_addr = 5'd3;
    bus.in_rd_we = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.ram_req_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_req_seen", 32'(bus.ram_req_valid), 32'd1);
    bus.ram_req_ready = 1'b1;
    @(negedge clk);
    bus.ram_req_ready = 1'b0;
    @(negedge clk);
    chk("rst_pre_state", 32'(dbg_state), 32'(WAIT_RSP));
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus.ram_rsp_valid = 1'b1;
    bus.ram_rsp_data  = 32'hA5A5A5A5;
    @(negedge clk);
    bus.ram_rsp_valid = 1'b0;
    saw_wb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      saw_wb = saw_wb | bus.wb_valid;
      @(negedge clk);
    end
    chk("rst_late_rsp_wb", 32'(saw_wb), 32'd0);
    chk_idle_outputs("rst_after");

    // Unit must still work normally after the mid-transaction reset.
    run_vec(21, vecs[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
